// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Issue-side controller for a 16-bit ALU. Accepts encoded
//               instructions on a valid/ready handshake, reads operands from
//               an internal register file, drives the ALU inputs for one
//               cycle, captures the result and C/Z flags, writes back and
//               presents the result on a valid/ready port.
// Ports       : clk, rst                          clock / sync active-high reset
//               instr_valid/ready, instr          instruction handshake
//               host_wr_en/addr/data              host register-file write
//               alu_a/b/select/mode/carry_in      ALU operand and control
//               alu_result                        combinational ALU output
//               res_valid/ready, res_data,
//               res_c, res_z                      result handshake and flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu_sequencer #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic              host_wr_en,
  input  logic [REG_AW-1:0] host_wr_addr,
  input  logic [DATA_W-1:0] host_wr_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_select,
  output logic              alu_mode,
  output logic              alu_carry_in,
  input  logic [DATA_W-1:0] alu_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_c,
  output logic              res_z
);

  localparam int NREG = 1 << REG_AW;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // Instruction fields
  logic              instr_mode;
  logic [3:0]        instr_sel;
  logic [REG_AW-1:0] instr_rd;
  logic [REG_AW-1:0] instr_ra;
  logic [REG_AW-1:0] instr_rb;
  logic              instr_cin_en;
  logic              instr_nowb;

  assign instr_mode   = instr[15];
  assign instr_sel    = instr[14:11];
  assign instr_rd     = instr[8 +: REG_AW];
  assign instr_ra     = instr[5 +: REG_AW];
  assign instr_rb     = instr[2 +: REG_AW];
  assign instr_cin_en = instr[1];
  assign instr_nowb   = instr[0];

  logic [1:0]        state_q,        state_d;
  logic [DATA_W-1:0] alu_a_q,        alu_a_d;
  logic [DATA_W-1:0] alu_b_q,        alu_b_d;
  logic [3:0]        alu_select_q,   alu_select_d;
  logic              alu_mode_q,     alu_mode_d;
  logic              alu_carry_in_q, alu_carry_in_d;
  logic [REG_AW-1:0] rd_q,           rd_d;
  logic              nowb_q,         nowb_d;
  logic              c_q,            c_d;
  logic              z_q,            z_d;
  logic [DATA_W-1:0] res_data_q,     res_data_d;
  logic              res_valid_q,    res_valid_d;
  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];

  logic              accept;
  logic              host_wr_fire;
  logic [DATA_W-1:0] opa_rd;
  logic [DATA_W-1:0] opb_rd;
  logic [DATA_W:0]   add_ext;
  logic [DATA_W:0]   sub_rhs;

  assign instr_ready  = (state_q == IDLE) && !rst;
  assign accept       = instr_valid && instr_ready;
  // Host writes are only honoured while idle; in EXEC/RESP they are dropped.
  assign host_wr_fire = host_wr_en && (state_q == IDLE);

  // Write-through: a host write in the accept cycle is visible to the read.
  assign opa_rd = (host_wr_fire && host_wr_addr == instr_ra) ? host_wr_data : regs_q[instr_ra];
  assign opb_rd = (host_wr_fire && host_wr_addr == instr_rb) ? host_wr_data : regs_q[instr_rb];

  // Flags are derived from the driven operands, not from the ALU carry output.
  assign add_ext = {1'b0, alu_a_q} + {1'b0, alu_b_q} + {{DATA_W{1'b0}}, alu_carry_in_q};
  assign sub_rhs = {1'b0, alu_b_q} + {{DATA_W{1'b0}}, alu_carry_in_q};

  always_comb begin
    state_d        = state_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_select_d   = alu_select_q;
    alu_mode_d     = alu_mode_q;
    alu_carry_in_d = alu_carry_in_q;
    rd_d           = rd_q;
    nowb_d         = nowb_q;
    c_d            = c_q;
    z_d            = z_q;
    res_data_d     = res_data_q;
    res_valid_d    = res_valid_q;
    regs_d         = regs_q;

    case (state_q)
      IDLE: begin
        if (host_wr_fire) begin
          regs_d[host_wr_addr] = host_wr_data;
        end
        if (accept) begin
          // ALU inputs are registered here so they are stable through EXEC
          // and keep their values afterwards.
          alu_a_d        = opa_rd;
          alu_b_d        = opb_rd;
          alu_select_d   = instr_sel;
          alu_mode_d     = instr_mode;
          alu_carry_in_d = instr_cin_en & c_q;
          rd_d           = instr_rd;
          nowb_d         = instr_nowb;
          state_d        = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = alu_result;
        z_d         = (alu_result == '0);
        if (!alu_mode_q && alu_select_q == 4'b0000) begin
          c_d = add_ext[DATA_W];
        end else if (!alu_mode_q && alu_select_q == 4'b0001) begin
          c_d = ({1'b0, alu_a_q} < sub_rhs);
        end else begin
          c_d = 1'b0;
        end
        if (!nowb_q) begin
          regs_d[rd_q] = alu_result;
        end
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_select_q   <= '0;
      alu_mode_q     <= 1'b0;
      alu_carry_in_q <= 1'b0;
      rd_q           <= '0;
      nowb_q         <= 1'b0;
      c_q            <= 1'b0;
      z_q            <= 1'b0;
      res_data_q     <= '0;
      res_valid_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_select_q   <= alu_select_d;
      alu_mode_q     <= alu_mode_d;
      alu_carry_in_q <= alu_carry_in_d;
      rd_q           <= rd_d;
      nowb_q         <= nowb_d;
      c_q            <= c_d;
      z_q            <= z_d;
      res_data_q     <= res_data_d;
      res_valid_q    <= res_valid_d;
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_select   = alu_select_q;
  assign alu_mode     = alu_mode_q;
  assign alu_carry_in = alu_carry_in_q;
  assign res_valid    = res_valid_q;
  assign res_data     = res_data_q;
  assign res_c        = c_q;
  assign res_z        = z_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer. Provides a behavioural
//               16-bit ALU and a reference model of the register file and
//               flags; compares the DUT against the model per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

  logic        clk;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        host_wr_en;
  logic [2:0]  host_wr_addr;
  logic [15:0] host_wr_data;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [3:0]  alu_select;
  logic        alu_mode;
  logic        alu_carry_in;
  logic [15:0] alu_result;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_c;
  logic        res_z;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] m_regs [8];
  logic        m_c;
  logic        m_z;

  alu_sequencer #(.DATA_W(16), .REG_AW(3)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select), .alu_mode(alu_mode),
    .alu_carry_in(alu_carry_in), .alu_result(alu_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_c(res_c), .res_z(res_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: reserved selects return zero.
  function automatic logic [15:0] alu_f(input logic mode, input logic [3:0] sel,
                                        input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    logic [15:0] r;
    r = 16'h0000;
    if (!mode) begin
      case (sel)
        4'd0:  r = a + b + {15'b0, cin};
        4'd1:  r = a - b - {15'b0, cin};
        4'd2:  r = a + 16'd1;
        4'd3:  r = a - 16'd1;
        4'd4:  r = b;
        4'd5:  r = a;
        4'd6:  r = -a;
        4'd7:  r = a << 1;
        4'd8:  r = a >> 1;
        4'd9:  r = a + b;
        4'd10: r = a ^ b;
        default: r = 16'h0000;
      endcase
    end else begin
      case (sel)
        4'd0: r = a & b;
        4'd1: r = a | b;
        4'd2: r = a ^ b;
        4'd3: r = ~a;
        4'd4: r = ~(a & b);
        4'd5: r = ~(a | b);
        4'd6: r = ~(a ^ b);
        4'd7: r = a;
        4'd8: r = b;
        default: r = 16'h0000;
      endcase
    end
    return r;
  endfunction

  always_comb alu_result = alu_f(alu_mode, alu_select, alu_a, alu_b, alu_carry_in);

  function automatic logic [15:0] enc(input logic mode, input logic [3:0] sel,
                                      input logic [2:0] rd, input logic [2:0] ra,
                                      input logic [2:0] rb, input logic cin_en,
                                      input logic nowb);
    return {mode, sel, rd, ra, rb, cin_en, nowb};
  endfunction

  // Expected outcome of an instruction from the current model state.
  function automatic void predict(input logic [15:0] ins, output logic [15:0] a,
                                  output logic [15:0] b, output logic cin,
                                  output logic [15:0] res, output logic c,
                                  output logic z);
    logic       mode;
    logic [3:0] sel;
    mode = ins[15];
    sel  = ins[14:11];
    a    = m_regs[ins[7:5]];
    b    = m_regs[ins[4:2]];
    cin  = ins[1] ? m_c : 1'b0;
    res  = alu_f(mode, sel, a, b, cin);
    if (!mode && sel == 4'd0)      c = (int'(a) + int'(b) + int'(cin)) > 65535;
    else if (!mode && sel == 4'd1) c = int'(a) < (int'(b) + int'(cin));
    else                           c = 1'b0;
    z = (res == 16'h0000);
  endfunction

  // All tasks start and end #1 after a rising edge.
  task automatic host_write(input logic [2:0] addr, input logic [15:0] data);
    host_wr_en   = 1'b1;
    host_wr_addr = addr;
    host_wr_data = data;
    @(posedge clk); #1;
    host_wr_en   = 1'b0;
    m_regs[addr] = data;
  endtask

  task automatic run_instr(input logic [15:0] ins, input logic hw_same,
                           input logic [2:0] hw_addr, input logic [15:0] hw_data,
                           output logic [15:0] obs_res, output logic obs_c,
                           output logic obs_z);
    logic [15:0] ea, eb, eres;
    logic        ecin, ec, ez;
    if (hw_same) m_regs[hw_addr] = hw_data;
    predict(ins, ea, eb, ecin, eres, ec, ez);
    instr_valid  = 1'b1;
    instr        = ins;
    host_wr_en   = hw_same;
    host_wr_addr = hw_addr;
    host_wr_data = hw_data;
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_ready: instr_ready=%b required 1 (instr=%h)", instr_ready, ins);
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    host_wr_en  = 1'b0;
    n_checks++;
    if ({alu_a, alu_b, alu_select, alu_mode, alu_carry_in} !== {ea, eb, ins[14:11], ins[15], ecin}) begin
      n_fail++;
      $display("FAIL exec_drive: a=%h b=%h sel=%h mode=%b cin=%b required a=%h b=%h sel=%h mode=%b cin=%b",
               alu_a, alu_b, alu_select, alu_mode, alu_carry_in, ea, eb, ins[14:11], ins[15], ecin);
    end
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL exec_res_valid: res_valid=%b required 0", res_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({res_valid, res_data, res_c, res_z} !== {1'b1, eres, ec, ez}) begin
      n_fail++;
      $display("FAIL resp_result: valid=%b data=%h c=%b z=%b required valid=1 data=%h c=%b z=%b (instr=%h)",
               res_valid, res_data, res_c, res_z, eres, ec, ez, ins);
    end
    obs_res = res_data;
    obs_c   = res_c;
    obs_z   = res_z;
    if (!ins[0]) m_regs[ins[10:8]] = eres;
    m_c = ec;
    m_z = ez;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_checks++;
    if ({res_valid, instr_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL after_handshake: res_valid=%b instr_ready=%b required 0 1", res_valid, instr_ready);
    end
  endtask

  // Readback of Rx through ADD Rx+R0 (R0 held at zero) with no write-back.
  task automatic readback(input logic [2:0] x, input logic [15:0] expv);
    logic [15:0] r;
    logic        c, z;
    run_instr(enc(1'b0, 4'd0, 3'd0, x, 3'd0, 1'b0, 1'b1), 1'b0, 3'd0, 16'h0, r, c, z);
    n_checks++;
    if (r !== expv) begin
      n_fail++;
      $display("FAIL readback_r%0d: got %h required %h", x, r, expv);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (instr_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: instr_ready=%b required 0", instr_ready);
    end
    n_checks++;
    if ({res_valid, res_data, res_c, res_z, alu_a, alu_b, alu_select, alu_mode, alu_carry_in} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b data=%h c=%b z=%b a=%h b=%h sel=%h mode=%b cin=%b required all 0",
               res_valid, res_data, res_c, res_z, alu_a, alu_b, alu_select, alu_mode, alu_carry_in);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (instr_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: instr_ready=%b required 1", instr_ready);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_c = 1'b0;
    m_z = 1'b0;
  endtask

  task automatic test_add_basic;
    logic [15:0] r;
    logic        c, z;
    host_write(3'd1, 16'hFFFF);
    host_write(3'd2, 16'h0001);
    run_instr(enc(1'b0, 4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 1'b0), 1'b0, 3'd0, 16'h0, r, c, z);
    n_checks++;
    if ({r, c, z} !== {16'h0000, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL add_wrap: data=%h c=%b z=%b required 0000 1 1", r, c, z);
    end
    readback(3'd3, 16'h0000);
  endtask

  task automatic test_add_carry;
    logic [15:0] r;
    logic        c, z;
    // Re-establish C=1 (the readback above cleared it).
    run_instr(enc(1'b0, 4'd0, 3'd3, 3'd1, 3'd2, 1'b0, 1'b1), 1'b0, 3'd0, 16'h0, r, c, z);
    host_write(3'd4, 16'h0001);
    host_write(3'd5, 16'h0002);
    run_instr(enc(1'b0, 4'd0, 3'd6, 3'd4, 3'd5, 1'b1, 1'b0), 1'b0, 3'd0, 16'h0, r, c, z);
    n_checks++;
    if ({r, c, z} !== {16'h0004, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL add_cin: data=%h c=%b z=%b required 0004 0 0", r, c, z);
    end
  endtask

  task automatic test_sub_compare;
    logic [15:0] r;
    logic        c, z;
    run_instr(enc(1'b0, 4'd1, 3'd7, 3'd2, 3'd1, 1'b0, 1'b1), 1'b0, 3'd0, 16'h0, r, c, z);
    n_checks++;
    if ({r, c, z} !== {16'h0002, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL sub_compare: data=%h c=%b z=%b required 0002 1 0", r, c, z);
    end
    readback(3'd7, 16'h0000);
    readback(3'd1, 16'hFFFF);
    readback(3'd2, 16'h0001);
  endtask

  task automatic test_logic_and;
    logic [15:0] r;
    logic        c, z;
    host_write(3'd6, 16'h00F0);
    host_write(3'd7, 16'h0F00);
    run_instr(enc(1'b1, 4'd0, 3'd5, 3'd6, 3'd7, 1'b0, 1'b0), 1'b0, 3'd0, 16'h0, r, c, z);
    n_checks++;
    if ({r, c, z} !== {16'h0000, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL logic_and: data=%h c=%b z=%b required 0000 0 1", r, c, z);
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] eres, ea, eb, r;
    logic        ecin, ec, ez, c, z;
    logic [15:0] ins;
    host_write(3'd1, 16'h1234);
    host_write(3'd2, 16'h1111);
    ins = enc(1'b0, 4'd0, 3'd4, 3'd1, 3'd2, 1'b0, 1'b0);
    predict(ins, ea, eb, ecin, eres, ec, ez);
    instr_valid = 1'b1;
    instr       = ins;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      host_wr_en   = (i % 2 == 0);
      host_wr_addr = 3'd2;
      host_wr_data = 16'hDEAD;
      n_checks++;
      if ({res_valid, res_data, res_c, res_z, instr_ready} !== {1'b1, eres, ec, ez, 1'b0}) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid=%b data=%h c=%b z=%b ready=%b required 1 %h %b %b 0",
                 i, res_valid, res_data, res_c, res_z, instr_ready, eres, ec, ez);
      end
      @(posedge clk); #1;
    end
    host_wr_en = 1'b0;
    m_regs[4] = eres;
    m_c = ec;
    m_z = ez;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    // run_instr checks instr_ready in this very cycle.
    run_instr(enc(1'b0, 4'd0, 3'd0, 3'd2, 3'd0, 1'b0, 1'b1), 1'b0, 3'd0, 16'h0, r, c, z);
    n_checks++;
    if (r !== 16'h1111) begin
      n_fail++;
      $display("FAIL stall_host_drop: R2=%h required 1111", r);
    end
    readback(3'd4, 16'h2345);
  endtask

  task automatic test_write_through;
    logic [15:0] r;
    logic        c, z;
    // Host write to R3 in the accept cycle; the operand read must see it.
    run_instr(enc(1'b0, 4'd9, 3'd6, 3'd3, 3'd3, 1'b0, 1'b0), 1'b1, 3'd3, 16'h0101, r, c, z);
    n_checks++;
    if (r !== 16'h0202) begin
      n_fail++;
      $display("FAIL write_through: data=%h required 0202", r);
    end
  endtask

  task automatic test_random;
    logic [15:0] r, ins;
    logic        c, z;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 3) == 0)
        host_write(3'($urandom_range(1, 7)), 16'($urandom));
      ins = 16'($urandom);
      if (ins[10:8] == 3'd0) ins[10:8] = 3'd1;
      if ($urandom_range(0, 4) == 0)
        run_instr(ins, 1'b1, 3'($urandom_range(1, 7)), 16'($urandom), r, c, z);
      else
        run_instr(ins, 1'b0, 3'd0, 16'h0, r, c, z);
    end
    for (int i = 1; i < 8; i++) readback(3'(i), m_regs[i]);
  endtask

  task automatic test_reset_mid;
    host_write(3'd6, 16'h1234);
    instr_valid = 1'b1;
    instr       = enc(1'b0, 4'd0, 3'd6, 3'd6, 3'd6, 1'b0, 1'b0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    n_checks++;
    if (alu_a !== 16'h1234) begin
      n_fail++;
      $display("FAIL midrst_exec: alu_a=%h required 1234", alu_a);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({res_valid, res_c, res_z, instr_ready, alu_a} !== {4'b0000, 16'h0000}) begin
      n_fail++;
      $display("FAIL midrst_state: valid=%b c=%b z=%b ready=%b alu_a=%h required 0 0 0 0 0000",
               res_valid, res_c, res_z, instr_ready, alu_a);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
    m_c = 1'b0;
    m_z = 1'b0;
    @(posedge clk); #1;
    readback(3'd6, 16'h0000);
  endtask

  initial begin
    rst          = 1'b1;
    instr_valid  = 1'b0;
    instr        = 16'h0;
    host_wr_en   = 1'b0;
    host_wr_addr = 3'd0;
    host_wr_data = 16'h0;
    res_ready    = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_add_basic;
    test_add_carry;
    test_sub_compare;
    test_logic_and;
    test_backpressure;
    test_write_through;
    test_random;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
